// File: rtl/branch_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// branch_hazard_ctrl_pkg
//
// Shared scpu definitions used by the fetch-side control-hazard controller:
//   - bh_state_e : FSM state encoding (IDLE / WAIT_RESOLVE / REDIRECT)
//   - NOP_INSN   : instruction word loaded into IF/ID when a bubble is injected
//                  (addi x0, x0, 0)
//   - bh_state_name : readable state name for debug prints
//
// Optional feature macro used by the files importing this package:
//   BRANCH_HAZARD_PERF_EN
// -----------------------------------------------------------------------------
package branch_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    BH_IDLE     = 2'd0,
    BH_WAIT     = 2'd1,
    BH_REDIRECT = 2'd2
  } bh_state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  function automatic string bh_state_name(input bh_state_e s);
    case (s)
      BH_IDLE:     return "IDLE";
      BH_WAIT:     return "WAIT_RESOLVE";
      BH_REDIRECT: return "REDIRECT";
      default:     return "ILLEGAL";
    endcase
  endfunction

endpackage

// File: rtl/branch_hazard_ctrl_perf.sv
// -----------------------------------------------------------------------------
// branch_hazard_perf
//
// Pair of saturating performance counters for the control-hazard controller.
// Both counters stick at all-ones and are cleared only by reset.
//
// Ports:
//   clk            in  : system clock
//   rstn           in  : synchronous active-low reset
//   count_stall    in  : controller spent this cycle waiting for a resolve
//   count_branch   in  : controller accepted a new control instruction
//   stall_cycles   out : CNT_WIDTH saturating count of count_stall cycles
//   branch_count   out : CNT_WIDTH saturating count of count_branch cycles
//
// Only instantiated when BRANCH_HAZARD_PERF_EN is defined.
// -----------------------------------------------------------------------------
module branch_hazard_perf #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 count_stall,
  input  logic                 count_branch,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] branch_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cycles <= '0;
    end else if (count_stall && (stall_cycles != CNT_MAX)) begin
      stall_cycles <= stall_cycles + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      branch_count <= '0;
    end else if (count_branch && (branch_count != CNT_MAX)) begin
      branch_count <= branch_count + CNT_ONE;
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// branch_hazard_ctrl
//
// Fetch-side control-hazard controller. When fetch flags a branch/JAL/JALR,
// the controller freezes the PC and feeds bubbles into IF/ID until execute
// resolves the instruction; a taken outcome is followed by a one-cycle
// redirect of the PC. There is no prediction.
//
// Ports:
//   clk, rstn                       : clock, synchronous active-low reset
//   branchhazardin_if_valid         : IF holds a valid instruction
//   branchhazardin_is_branch_jump   : that instruction is a branch/JAL/JALR
//   branchhazardin_flush            : trap/exception flush from writeback
//   branchhazardin_resolve_valid    : execute resolves the in-flight insn
//   branchhazardin_resolve_taken    : resolved outcome is taken
//   branchhazardin_resolve_target   : resolved target address
//   branchhazardout_stall_fetch     : hold the PC register
//   branchhazardout_bubble          : load NOP into IF/ID
//   branchhazardout_redirect_valid  : load redirect_pc into the PC
//   branchhazardout_redirect_pc     : registered redirect address
//   branchhazardout_stall_cycles    : cycles spent in WAIT_RESOLVE
//   branchhazardout_branch_count    : control instructions accepted
//   debug_state                     : current FSM state (observability)
//
// Handshake: the resolve interface is a one-shot strobe with no back-pressure;
// resolve_valid is only acted on in WAIT_RESOLVE and is dropped in every other
// state. Detection (if_valid && is_branch_jump) is likewise only acted on in
// IDLE. flush overrides every transition except reset.
//
// Configuration macro: BRANCH_HAZARD_PERF_EN
//   defined   : counters are live (branch_hazard_perf is instantiated)
//   undefined : counter ports are tied to zero, no counter flops exist
// -----------------------------------------------------------------------------
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 branchhazardin_if_valid,
  input  logic                 branchhazardin_is_branch_jump,
  input  logic                 branchhazardin_flush,
  input  logic                 branchhazardin_resolve_valid,
  input  logic                 branchhazardin_resolve_taken,
  input  logic [PC_WIDTH-1:0]  branchhazardin_resolve_target,
  output logic                 branchhazardout_stall_fetch,
  output logic                 branchhazardout_bubble,
  output logic                 branchhazardout_redirect_valid,
  output logic [PC_WIDTH-1:0]  branchhazardout_redirect_pc,
  output logic [CNT_WIDTH-1:0] branchhazardout_stall_cycles,
  output logic [CNT_WIDTH-1:0] branchhazardout_branch_count,
  output bh_state_e            debug_state
);

  // JALR targets may carry bit 0 set; the PC is always halfword aligned.
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(1);

  bh_state_e state_q;
  bh_state_e state_d;

  logic detect;
  logic take_redirect;

  assign detect        = branchhazardin_if_valid && branchhazardin_is_branch_jump;
  // A flushed resolve must not disturb the redirect register either.
  assign take_redirect = (state_q == BH_WAIT) && !branchhazardin_flush &&
                         branchhazardin_resolve_valid && branchhazardin_resolve_taken;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= BH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (branchhazardin_flush) begin
      state_d = BH_IDLE;
    end else begin
      case (state_q)
        BH_IDLE: begin
          // A resolve seen here is spurious and ignored, even alongside detect.
          if (detect) begin
            state_d = BH_WAIT;
          end
        end
        BH_WAIT: begin
          if (branchhazardin_resolve_valid) begin
            state_d = branchhazardin_resolve_taken ? BH_REDIRECT : BH_IDLE;
          end
        end
        BH_REDIRECT: begin
          state_d = BH_IDLE;
        end
        default: begin
          state_d = BH_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs decoded from the state register
  // ---------------------------------------------------------------------------
  always_comb begin
    branchhazardout_stall_fetch    = 1'b0;
    branchhazardout_bubble         = 1'b0;
    branchhazardout_redirect_valid = 1'b0;
    case (state_q)
      BH_WAIT: begin
        branchhazardout_stall_fetch = 1'b1;
        branchhazardout_bubble      = 1'b1;
      end
      BH_REDIRECT: begin
        // PC moves to the target this cycle; the slot fetched meanwhile is
        // still on the wrong path, so it is squashed as well.
        branchhazardout_redirect_valid = 1'b1;
        branchhazardout_bubble         = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign debug_state = state_q;

  // ---------------------------------------------------------------------------
  // Redirect address register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      branchhazardout_redirect_pc <= '0;
    end else if (take_redirect) begin
      branchhazardout_redirect_pc <= branchhazardin_resolve_target & ALIGN_MASK;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef BRANCH_HAZARD_PERF_EN
  logic count_branch;

  // Counts the IDLE->WAIT_RESOLVE transition, so a flush on the detect cycle
  // (which keeps the FSM in IDLE) does not count.
  assign count_branch = (state_q == BH_IDLE) && detect && !branchhazardin_flush;

  branch_hazard_perf #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_perf (
    .clk          (clk),
    .rstn         (rstn),
    .count_stall  (state_q == BH_WAIT),
    .count_branch (count_branch),
    .stall_cycles (branchhazardout_stall_cycles),
    .branch_count (branchhazardout_branch_count)
  );
`else
  assign branchhazardout_stall_cycles = '0;
  assign branchhazardout_branch_count = '0;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_hazard_ctrl
//
// Directed scenarios followed by randomized traffic, every cycle compared
// against a behavioural model that tracks "a control instruction is in
// flight" and "a redirect is pending" plus saturating integer counters.
// Counter expectations follow BRANCH_HAZARD_PERF_EN.
// -----------------------------------------------------------------------------
module tb_branch_hazard_ctrl;
  import branch_hazard_ctrl_pkg::*;

  localparam int PW = 32;
  localparam int CW = 4;
`ifdef BRANCH_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int CNT_SAT = (1 << CW) - 1;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rstn;
  logic          if_valid, is_bj, flush, res_valid, res_taken;
  logic [PW-1:0] res_target;
  logic          stall_fetch, bubble, redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic [CW-1:0] stall_cycles, branch_count;
  bh_state_e     dbg_state;

  always #5 clk = ~clk;

  branch_hazard_ctrl #(
    .PC_WIDTH  (PW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk                            (clk),
    .rstn                           (rstn),
    .branchhazardin_if_valid        (if_valid),
    .branchhazardin_is_branch_jump  (is_bj),
    .branchhazardin_flush           (flush),
    .branchhazardin_resolve_valid   (res_valid),
    .branchhazardin_resolve_taken   (res_taken),
    .branchhazardin_resolve_target  (res_target),
    .branchhazardout_stall_fetch    (stall_fetch),
    .branchhazardout_bubble         (bubble),
    .branchhazardout_redirect_valid (redirect_valid),
    .branchhazardout_redirect_pc    (redirect_pc),
    .branchhazardout_stall_cycles   (stall_cycles),
    .branchhazardout_branch_count   (branch_count),
    .debug_state                    (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  bit            m_in_flight;   // waiting for execute to resolve
  bit            m_redirect;    // PC redirect happens this cycle
  logic [PW-1:0] m_pc;
  int            m_stalls;
  int            m_branches;
  logic [PW-1:0] exp_q[$];      // redirect targets not yet seen on the port

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < CNT_SAT) ? v + 1 : v;
  endfunction

  task automatic model_edge(input logic rn, iv, bj, fl, rv, rt, input logic [PW-1:0] tg);
    if (!rn) begin
      m_in_flight = 0;
      m_redirect  = 0;
      m_pc        = '0;
      m_stalls    = 0;
      m_branches  = 0;
      exp_q.delete();
      return;
    end
    if (m_in_flight) m_stalls = sat_inc(m_stalls);
    if (!m_in_flight && !m_redirect && iv && bj && !fl) m_branches = sat_inc(m_branches);
    if (fl) begin
      m_in_flight = 0;
      m_redirect  = 0;
    end else if (m_redirect) begin
      m_redirect = 0;
    end else if (m_in_flight) begin
      if (rv) begin
        m_in_flight = 0;
        if (rt) begin
          m_redirect = 1;
          m_pc       = {tg[PW-1:1], 1'b0};
          exp_q.push_back(m_pc);
        end
      end
    end else if (iv && bj) begin
      m_in_flight = 1;
    end
  endtask

  task automatic compare_all();
    bh_state_e exp_state;
    logic [PW-1:0] tgt;
    exp_state = m_in_flight ? BH_WAIT : (m_redirect ? BH_REDIRECT : BH_IDLE);
    check("state", PW'(dbg_state), PW'(exp_state));
    check("stall_fetch", PW'(stall_fetch), PW'(m_in_flight));
    check("bubble", PW'(bubble), PW'(m_in_flight | m_redirect));
    check("redirect_valid", PW'(redirect_valid), PW'(m_redirect));
    check("redirect_pc", redirect_pc, m_pc);
    check("stall_cycles", PW'(stall_cycles), PERF ? PW'(m_stalls) : '0);
    check("branch_count", PW'(branch_count), PERF ? PW'(m_branches) : '0);
    if (m_redirect) begin
      tgt = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check("sb_redirect_target", redirect_pc, tgt);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply one cycle of inputs, advance the model, compare after edge
  // ---------------------------------------------------------------------------
  task automatic step(input logic rn, iv, bj, fl, rv, rt, input logic [PW-1:0] tg);
    rstn = rn; if_valid = iv; is_bj = bj; flush = fl;
    res_valid = rv; res_taken = rt; res_target = tg;
    @(posedge clk);
    model_edge(rn, iv, bj, fl, rv, rt, tg);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, '0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rstn = 0; if_valid = 0; is_bj = 0; flush = 0;
    res_valid = 0; res_taken = 0; res_target = '0;
    m_in_flight = 0; m_redirect = 0; m_pc = '0; m_stalls = 0; m_branches = 0;

    // Reset held for two cycles with every input toggling.
    step(0, 1, 1, 0, 1, 1, 32'hFFFF_FFFF);
    step(0, 0, 1, 1, 1, 0, 32'h1234_5679);
    check("reset_stall", PW'(stall_fetch), '0);
    check("reset_redirect_pc", redirect_pc, '0);
    idle(2);

    // BEQ: detect, one waiting cycle, resolve not-taken.
    step(1, 1, 1, 0, 0, 0, '0);
    step(1, 0, 0, 0, 0, 0, '0);
    check("beq_stall_mid", PW'(stall_fetch), 32'd1);
    step(1, 1, 1, 0, 1, 0, 32'h0000_0040);
    check("beq_released", PW'(stall_fetch), '0);
    check("beq_no_redirect", PW'(redirect_valid), '0);
    check("beq_branch_count", PW'(branch_count), PERF ? 32'd1 : '0);
    check("beq_stall_cycles", PW'(stall_cycles), PERF ? 32'd2 : '0);
    idle(1);

    // JAL resolved taken on the very next cycle.
    step(1, 1, 1, 0, 0, 0, '0);
    step(1, 0, 0, 0, 1, 1, 32'h0000_0100);
    check("jal_redirect_valid", PW'(redirect_valid), 32'd1);
    check("jal_redirect_pc", redirect_pc, 32'h0000_0100);
    step(1, 0, 0, 0, 0, 0, '0);
    check("jal_redirect_once", PW'(redirect_valid), '0);

    // JALR with odd target: bit 0 is cleared.
    step(1, 1, 1, 0, 0, 0, '0);
    step(1, 0, 0, 0, 0, 0, '0);
    step(1, 0, 0, 0, 1, 1, 32'h0000_0207);
    check("jalr_redirect_pc", redirect_pc, 32'h0000_0206);
    idle(1);

    // Flush colliding with a taken resolve: no redirect, PC register untouched.
    step(1, 1, 1, 0, 0, 0, '0);
    step(1, 0, 0, 1, 1, 1, 32'h0000_0800);
    check("flush_no_redirect", PW'(redirect_valid), '0);
    check("flush_idle", PW'(dbg_state), PW'(BH_IDLE));
    check("flush_keeps_pc", redirect_pc, 32'h0000_0206);

    // Detect and spurious resolve together in IDLE: detect wins.
    step(1, 1, 1, 0, 1, 1, 32'h0000_0900);
    check("detect_beats_resolve", PW'(stall_fetch), 32'd1);

    // Long wait: stall counter saturates.
    for (int i = 0; i < 20; i++) step(1, 1, 1, 0, 0, 0, '0);
    check("stall_saturated", PW'(stall_cycles), PERF ? PW'(CNT_SAT) : '0);
    step(1, 0, 0, 0, 1, 0, '0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) != 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)),
           $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
